buffer_streamer: RTL and testbench
==================================

# buffer_streamer

Read-side sequencer placed directly downstream of the byte-wide operand `buffer`. On a `start` pulse it issues a burst of reads from a base address. It absorbs the buffer's one-cycle registered read latency and presents the bytes as a valid/ready stream to the compute array, marking the last byte of each burst. Backpressure from the consumer is handled by an internal 4-entry FIFO with credit-based read issue, so no byte is ever dropped or duplicated.

## Interface
- `Depth`, 32: entries in the attached buffer; addresses wrap modulo `Depth`.
- `DataWidth`, 8: byte width of buffer data and stream data.
- `AddrWidth`, `$clog2(Depth)`: buffer address width.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `baseAddr`  in  AddrWidth  first read address; sampled with `start`.
- `length`  in  AddrWidth+1  byte count, 0..`Depth`; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the burst completes.
- `readEn`  out  1  read strobe to the buffer.
- `readAddr`  out  AddrWidth  read address to the buffer.
- `bufData`  in  DataWidth  buffer `dataOut`; valid the cycle after `readEn`.
- `outData`  out  DataWidth  stream byte (FIFO head).
- `outValid`  out  1  `outData` is valid.
- `outReady`  in  1  consumer accepts; a transfer occurs when `outValid && outReady`.
- `outLast`  out  1  qualifies the final byte of the burst.

## Operation
- States:
  - IDLE: `busy` = 0.
  - READ: reads remain to be issued.
  - DRAIN: all reads issued; waiting for the FIFO and the in-flight read to empty.
- IDLE with `start` = 1 and `length` > 0: latch the address and count, then go to READ.
- IDLE with `start` = 1 and `length` = 0: pulse `done` the next cycle, issue no reads, and stay IDLE.
- `start` while not IDLE is ignored.
- Issue rule in READ: `readEn` = 1 iff `fifoCount + inflight <= 2`. `inflight` is a 1-bit register set when `readEn` was high in the previous cycle.
- Issue rule is registered state only; it has no combinational dependence on `outReady`.
- Each issue:
  - `readAddr` increments by 1 modulo `Depth`, so `Depth-1` is followed by 0.
  - The remaining-issue counter decrements.
  - When it reaches 0, go to DRAIN.
- `bufData` is pushed into the FIFO on the cycle after each `readEn`. The FIFO never overflows (max occupancy 3 of 4).
- The FIFO pops on each transfer. Push and pop in the same cycle leave the count unchanged.
- A separate remaining-output counter drives `outLast`: `outLast` = `outValid` and remaining-output = 1.
- DRAIN exits when the transfer with `outLast` occurs. `done` pulses in the following cycle; the state returns to IDLE at the same time.
- A new `start` is accepted in the cycle `done` is high.
- `readAddr` is driven with the current address even when `readEn` = 0. The buffer ignores it.
- Asserting `rst` mid-burst discards all FIFO contents and the in-flight read. The next burst starts clean.

## Timing
- Reset values: `busy` = 0, `done` = 0, `readEn` = 0, `readAddr` = 0, `outValid` = 0, `outLast` = 0, `outData` = 0. FIFO is empty, `inflight` = 0, state is IDLE.
- `start` sampled at edge 0:
  - `busy` = 1 and the first `readEn` occur in cycle 1.
  - `bufData` is captured at the end of cycle 2.
  - First `outValid` is in cycle 3.
- Latency from `start` to first `outValid` is 3 cycles.
- With `outReady` held high, throughput is 1 byte per cycle.
- An N-byte burst has its last transfer in cycle N+2 and `done` in cycle N+3.
- While `outValid && !outReady`, `outData` and `outLast` hold stable. `outValid` never drops without a transfer.
- With `outReady` low, issue stops after at most 3 outstanding bytes. Issue resumes 1 cycle after the FIFO drains to ≤ 2 occupancy.

## Test plan
- Basic burst: reset, buffer preloaded with `mem[i] = i + 0x10`; `start`, `baseAddr` = 4, `length` = 5, `outReady` = 1.
  - Stream is 0x14..0x18 on cycles 3..7.
  - `outLast` is high only on 0x18.
  - `done` is high in cycle 8.
- Wrap: `baseAddr` = 30, `length` = 4, `Depth` = 32.
  - `readAddr` sequence is 30, 31, 0, 1.
  - Data is 0x2E, 0x2F, 0x10, 0x11.
- Backpressure: `length` = 8 with `outReady` toggling 1,0,0,1,0,…
  - All 8 bytes arrive in order with none duplicated.
  - `outData` is stable during every stall.
  - `readEn` never fires with `fifoCount + inflight` > 2.
- Zero length: `start` with `length` = 0.
  - `done` is high the next cycle.
  - `readEn` stays 0 and `outValid` stays 0.
  - `busy` stays 0.
- Ignored start and reset mid-burst:
  - A second `start` during a 6-byte burst has no effect.
  - Asserting `rst` at cycle 5 forces all outputs to their reset values immediately.
  - After `rst` is released, a fresh `length` = 2 burst yields exactly 2 correct bytes.
- Back-to-back: `start` reasserted in the `done` cycle with `length` = 3 is accepted. Its first `outValid` comes 3 cycles later.

Source files
------------

// File: rtl/buffer_streamer_if.sv
// Bundles the streamer's control, buffer-read and output-stream signals.
// The streamer side uses master; the surrounding logic uses slave.
interface buffer_streamer_if #(
  parameter int Depth     = 32,
  parameter int DataWidth = 8,
  parameter int AddrWidth = $clog2(Depth)
);
  logic                 start;
  logic [AddrWidth-1:0] baseAddr;
  logic [AddrWidth:0]   length;
  logic                 busy;
  logic                 done;
  logic                 readEn;
  logic [AddrWidth-1:0] readAddr;
  logic [DataWidth-1:0] bufData;
  logic [DataWidth-1:0] outData;
  logic                 outValid;
  logic                 outReady;
  logic                 outLast;

  modport master (
    input  start, baseAddr, length, bufData, outReady,
    output busy, done, readEn, readAddr, outData, outValid, outLast
  );

  modport slave (
    output start, baseAddr, length, bufData, outReady,
    input  busy, done, readEn, readAddr, outData, outValid, outLast
  );
endinterface

// File: rtl/buffer_streamer.sv
// Burst read sequencer: reads a registered-latency buffer and streams bytes out
// through a 4-entry FIFO, issuing reads only while FIFO space is guaranteed.
//
// state | meaning
// IDLE  | waiting for start, busy low
// READ  | reads remain to be issued
// DRAIN | all reads issued, emptying in-flight read and FIFO
module buffer_streamer #(
  parameter int Depth     = 32,
  parameter int DataWidth = 8
) (
  input  logic clk,
  input  logic rst,
  buffer_streamer_if.master bus
);
  localparam int AddrWidth = $clog2(Depth);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth:0]   issue_cnt_q, issue_cnt_d;
  logic [AddrWidth:0]   out_cnt_q, out_cnt_d;
  logic                 done_q, done_d;
  logic                 inflight_q;

  logic [DataWidth-1:0] fifo_q [4];
  logic [1:0]           wr_ptr_q, rd_ptr_q;
  logic [2:0]           count_q;

  logic read_en, push, pop, out_valid, out_last;

  // Credit check counts the in-flight read so a returning byte always has a slot.
  assign read_en   = (state_q == READ) && (({1'b0, count_q} + 4'(inflight_q)) <= 4'd2);
  assign push      = inflight_q;
  assign out_valid = (count_q != 3'd0);
  assign out_last  = out_valid && (out_cnt_q == (AddrWidth+1)'(1));
  assign pop       = out_valid && bus.outReady;

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.readEn   = read_en;
  assign bus.readAddr = addr_q;
  assign bus.outData  = fifo_q[rd_ptr_q];
  assign bus.outValid = out_valid;
  assign bus.outLast  = out_last;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            addr_d      = bus.baseAddr;
            issue_cnt_d = bus.length;
            out_cnt_d   = bus.length;
            state_d     = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (read_en) begin
          addr_d      = (addr_q == AddrWidth'(Depth-1)) ? '0 : addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q - 1'b1;
          if (issue_cnt_q == (AddrWidth+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase
    if (pop) begin
      out_cnt_d = out_cnt_q - 1'b1;
      if (out_last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      done_q      <= done_d;
      inflight_q  <= read_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.bufData;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end
endmodule

// File: tb/tb_buffer_streamer.sv
// Randomized scoreboard bench for buffer_streamer with a behavioural buffer model.
module tb_buffer_streamer;
  localparam int Depth = 32;

  logic clk = 1'b0;
  logic rst;
  buffer_streamer_if #(.Depth(Depth), .DataWidth(8)) bus ();
  buffer_streamer #(.Depth(Depth), .DataWidth(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; } exp_t;

  logic [7:0] mem [Depth];
  exp_t       exp_q [$];
  logic [4:0] addr_exp_q [$];
  int         outstanding = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Buffer with one-cycle registered read.
  always @(posedge clk or posedge rst)
    if (rst) bus.bufData <= '0;
    else if (bus.readEn) bus.bufData <= mem[bus.readAddr];

  // Monitor: stream scoreboard, read-address order, credit limit, stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      outstanding = 0;
      exp_q.delete();
      addr_exp_q.delete();
    end else begin
      if (prev_stall) begin
        check("stall_valid", bus.outValid, 1);
        check("stall_data", bus.outData, prev_data);
        check("stall_last", bus.outLast, prev_last);
      end
      if (bus.readEn) begin
        check("issue_credit", (outstanding <= 2), 1);
        if (addr_exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_read: got addr %0d expected no read", bus.readAddr);
        end else begin
          check("read_addr", bus.readAddr, addr_exp_q.pop_front());
        end
        outstanding++;
      end
      if (bus.outValid && bus.outReady) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_byte: got %0h expected no byte", bus.outData);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", bus.outData, e.data);
          check("out_last", bus.outLast, e.last);
        end
        outstanding--;
      end
      prev_stall = bus.outValid && !bus.outReady;
      prev_data  = bus.outData;
      prev_last  = bus.outLast;
    end
  end

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0: return 1'b1;
      1: return ((c - 1) % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic launch(input logic [4:0] base, input int len);
    bus.start    = 1'b1;
    bus.baseAddr = base;
    bus.length   = 6'(len);
    for (int k = 0; k < len; k++) begin
      exp_q.push_back('{mem[5'(base + k)], (k == len - 1)});
      addr_exp_q.push_back(5'(base + k));
    end
  endtask

  // Called right after launch; cycle c counts from the edge that samples start.
  task automatic run(input int len, input int mode, input bit ign, input int rst_cyc,
                     input int next_len, input logic [4:0] next_base);
    int first  = -1;
    int done_c = -1;
    bit saw_rd = 0;
    bit saw_busy = 0;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      bus.outReady = ready_for(mode, c);
      if (ign && c == 2) begin
        bus.start = 1'b1; bus.baseAddr = 5'd9; bus.length = 6'd3;
      end
      if (ign && c == 3) bus.start = 1'b0;
      if (c == rst_cyc) begin
        rst = 1'b1;
        #1;
        check("rst_outputs", {bus.busy, bus.done, bus.readEn, bus.readAddr,
                              bus.outValid, bus.outLast, bus.outData}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      if (bus.outValid && first < 0) first = c;
      saw_rd   |= bus.readEn;
      saw_busy |= bus.busy;
      if (bus.done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_c < 0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end else if (len == 0) begin
      check("zero_done_cycle", done_c, 1);
      check("zero_no_read", saw_rd, 0);
      check("zero_no_valid", first, -1);
      check("zero_no_busy", saw_busy, 0);
    end else begin
      if (mode == 0) begin
        check("first_valid_cycle", first, 3);
        check("done_cycle", done_c, len + 3);
      end
      check("bytes_left", exp_q.size(), 0);
      check("busy_at_done", bus.busy, 0);
    end
    if (next_len > 0 && done_c > 0) launch(next_base, next_len);
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) mem[i] = 8'(i + 16);
    rst = 1'b1;
    bus.start = 1'b0; bus.baseAddr = '0; bus.length = '0; bus.outReady = 1'b1;
    #1;
    check("reset_outputs", {bus.busy, bus.done, bus.readEn, bus.readAddr,
                            bus.outValid, bus.outLast, bus.outData}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    @(posedge clk); #1 launch(5'd4, 5);  run(5, 0, 0, 0, 0, 0);
    @(posedge clk); #1 launch(5'd30, 4); run(4, 0, 0, 0, 0, 0);
    @(posedge clk); #1 launch(5'd12, 8); run(8, 1, 0, 0, 0, 0);
    @(posedge clk); #1 launch(5'd5, 0);  run(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 launch(5'd20, 6); run(6, 0, 1, 0, 0, 0);
    @(posedge clk); #1 launch(5'd8, 6);  run(6, 0, 0, 5, 0, 0);
    @(posedge clk); #1 launch(5'd3, 2);  run(2, 0, 0, 0, 0, 0);
    @(posedge clk); #1 launch(5'd10, 4); run(4, 0, 0, 0, 3, 5'd25);
    run(3, 0, 0, 0, 0, 0);
    @(posedge clk); #1 launch(5'd0, 32); run(32, 0, 0, 0, 0, 0);

    for (int i = 0; i < Depth; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 8; t++) begin
      int len;
      len = $urandom_range(1, Depth);
      @(posedge clk); #1 launch(5'($urandom), len);
      run(len, 2, 0, 0, 0, 0);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
